// File: rtl/rom_loader.sv
// rom_loader: 8N1 UART boot loader that writes a framed, checksummed image into instruction ROM as 32-bit words.
// One write strobe the cycle after each 4th data byte; no backpressure, so the ROM must accept every strobe.
module rom_loader #(
  parameter int          CLK_DIV   = 434,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic        rom_we_o,
  output logic [31:0] rom_waddr_o,
  output logic [31:0] rom_wdata_o,
  output logic        core_hold_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int            TW       = $clog2(CLK_DIV);
  localparam logic [TW-1:0] BIT_END  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLK_DIV / 2 - 1);
  localparam logic [16:0]   LEN_MAX  = 17'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM} state_t;

  // ---------------- RX front end ----------------
  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     rx_state, rx_state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          byte_valid, frame_err;
  logic [7:0]    rx_byte;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      timer    <= timer_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
    end
  end

  // Every sample after the start check lands mid-bit, so the receiver is idle
  // again before the next start edge of a back-to-back byte arrives.
  always_comb begin
    rx_state_nxt = rx_state;
    timer_nxt    = timer;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    byte_valid   = 1'b0;
    frame_err    = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_nxt = RX_START;
          timer_nxt    = '0;
        end
      end
      RX_START: begin
        if (timer == HALF_END) begin
          timer_nxt   = '0;
          bit_cnt_nxt = '0;
          rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      RX_DATA: begin
        if (timer == BIT_END) begin
          timer_nxt   = '0;
          shreg_nxt   = {rx_sync, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx_state_nxt = RX_STOP;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      RX_STOP: begin
        if (timer == BIT_END) begin
          timer_nxt    = '0;
          rx_state_nxt = RX_IDLE;
          byte_valid   = rx_sync;
          frame_err    = !rx_sync;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  assign rx_byte = shreg;

  // ---------------- Frame parser ----------------
  state_t      state, state_nxt;
  logic [7:0]  len_lo, len_lo_nxt;
  logic [15:0] len, len_nxt;
  logic [15:0] word_idx, word_idx_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [31:0] word_asm, word_asm_nxt;
  logic [7:0]  csum, csum_nxt;
  logic        we_nxt, hold_nxt, done_nxt, err_nxt;
  logic [31:0] waddr_nxt, wdata_nxt;
  logic [15:0] len_full;
  logic [31:0] asm_word;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      len_lo      <= '0;
      len         <= '0;
      word_idx    <= '0;
      byte_cnt    <= '0;
      word_asm    <= '0;
      csum        <= '0;
      rom_we_o    <= 1'b0;
      rom_waddr_o <= '0;
      rom_wdata_o <= '0;
      core_hold_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_nxt;
      len_lo      <= len_lo_nxt;
      len         <= len_nxt;
      word_idx    <= word_idx_nxt;
      byte_cnt    <= byte_cnt_nxt;
      word_asm    <= word_asm_nxt;
      csum        <= csum_nxt;
      rom_we_o    <= we_nxt;
      rom_waddr_o <= waddr_nxt;
      rom_wdata_o <= wdata_nxt;
      core_hold_o <= hold_nxt;
      done_o      <= done_nxt;
      err_o       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    len_lo_nxt   = len_lo;
    len_nxt      = len;
    word_idx_nxt = word_idx;
    byte_cnt_nxt = byte_cnt;
    word_asm_nxt = word_asm;
    csum_nxt     = csum;
    we_nxt       = 1'b0;
    waddr_nxt    = rom_waddr_o;
    wdata_nxt    = rom_wdata_o;
    hold_nxt     = core_hold_o;
    done_nxt     = 1'b0;
    err_nxt      = err_o;
    len_full     = {rx_byte, len_lo};
    asm_word     = {rx_byte, word_asm[31:8]};

    if (frame_err) begin
      state_nxt = ST_IDLE;
      err_nxt   = 1'b1;
      hold_nxt  = 1'b0;
    end else if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == 8'hA5) begin
            state_nxt    = ST_LEN0;
            hold_nxt     = 1'b1;
            err_nxt      = 1'b0;
            word_idx_nxt = '0;
            byte_cnt_nxt = '0;
            csum_nxt     = '0;
          end
        end
        ST_LEN0: begin
          len_lo_nxt = rx_byte;
          state_nxt  = ST_LEN1;
        end
        ST_LEN1: begin
          len_nxt = len_full;
          if ({1'b0, len_full} > LEN_MAX) begin
            err_nxt   = 1'b1;
            hold_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end else if (len_full == 16'd0) begin
            state_nxt = ST_CSUM;
          end else begin
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          // Bytes shift in from the top, so after four the first byte sits in [7:0].
          word_asm_nxt = asm_word;
          csum_nxt     = csum ^ rx_byte;
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            we_nxt       = 1'b1;
            waddr_nxt    = ADDR_BASE + {14'd0, word_idx, 2'b00};
            wdata_nxt    = asm_word;
            word_idx_nxt = word_idx + 16'd1;
            if (word_idx + 16'd1 == len) state_nxt = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (rx_byte == csum) done_nxt = 1'b1;
          else                 err_nxt  = 1'b1;
          hold_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: drives 8N1 bytes at CLK_DIV=4 and checks ROM writes, done, hold and error.
module tb_rom_loader;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic        rom_we_o;
  logic [31:0] rom_waddr_o;
  logic [31:0] rom_wdata_o;
  logic        core_hold_o;
  logic        done_o;
  logic        err_o;

  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  logic [7:0]  good [12];

  always #5 clk = ~clk;

  rom_loader #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx),
    .rom_we_o    (rom_we_o),
    .rom_waddr_o (rom_waddr_o),
    .rom_wdata_o (rom_wdata_o),
    .core_hold_o (core_hold_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  // Write/done recorder
  always @(negedge clk) begin
    if (rom_we_o) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = rom_waddr_o;
        wr_data[wr_cnt] = rom_wdata_o;
      end
      wr_cnt++;
    end
    if (done_o) done_cnt++;
  end

  task automatic clear_mon();
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = stop;
    repeat (CLK_DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_good(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(good[i], 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (rom_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", rom_we_o); end
    n_vec++; if (rom_waddr_o !== 32'h0) begin n_err++; $display("FAIL reset_waddr got %h want 0", rom_waddr_o); end
    n_vec++; if (rom_wdata_o !== 32'h0) begin n_err++; $display("FAIL reset_wdata got %h want 0", rom_wdata_o); end
    n_vec++; if (core_hold_o !== 1'b0) begin n_err++; $display("FAIL reset_hold got %b want 0", core_hold_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err_o); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame();
    clear_mon();
    send_good(0, 1);
    n_vec++; if (core_hold_o !== 1'b1) begin n_err++; $display("FAIL good_hold_mid got %b want 1", core_hold_o); end
    send_good(2, 11);
    repeat (12) @(negedge clk);
    n_vec++; if (wr_cnt !== 2) begin n_err++; $display("FAIL good_wr_cnt got %0d want 2", wr_cnt); end
    n_vec++; if (wr_addr[0] !== 32'h0) begin n_err++; $display("FAIL good_addr0 got %h want 00000000", wr_addr[0]); end
    n_vec++; if (wr_data[0] !== 32'h9300_0013) begin n_err++; $display("FAIL good_data0 got %h want 93000013", wr_data[0]); end
    n_vec++; if (wr_addr[1] !== 32'h4) begin n_err++; $display("FAIL good_addr1 got %h want 00000004", wr_addr[1]); end
    n_vec++; if (wr_data[1] !== 32'h0000_0537) begin n_err++; $display("FAIL good_data1 got %h want 00000537", wr_data[1]); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL good_done_cnt got %0d want 1", done_cnt); end
    n_vec++; if (core_hold_o !== 1'b0) begin n_err++; $display("FAIL good_hold_end got %b want 0", core_hold_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL good_err got %b want 0", err_o); end
    n_vec++; if (rom_wdata_o !== 32'h0000_0537) begin n_err++; $display("FAIL good_wdata_hold got %h want 00000537", rom_wdata_o); end
  endtask

  task automatic test_noise();
    clear_mon();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    n_vec++; if (core_hold_o !== 1'b0) begin n_err++; $display("FAIL noise_hold got %b want 0", core_hold_o); end
    send_good(0, 11);
    repeat (12) @(negedge clk);
    n_vec++; if (wr_cnt !== 2) begin n_err++; $display("FAIL noise_wr_cnt got %0d want 2", wr_cnt); end
    n_vec++; if (wr_data[0] !== 32'h9300_0013) begin n_err++; $display("FAIL noise_data0 got %h want 93000013", wr_data[0]); end
    n_vec++; if (wr_addr[1] !== 32'h4) begin n_err++; $display("FAIL noise_addr1 got %h want 00000004", wr_addr[1]); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL noise_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_bad_csum();
    clear_mon();
    send_good(0, 10);
    send_byte(8'h00, 1'b1);
    repeat (12) @(negedge clk);
    n_vec++; if (wr_cnt !== 2) begin n_err++; $display("FAIL csum_wr_cnt got %0d want 2", wr_cnt); end
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL csum_err got %b want 1", err_o); end
    n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL csum_done_cnt got %0d want 0", done_cnt); end
    n_vec++; if (core_hold_o !== 1'b0) begin n_err++; $display("FAIL csum_hold got %b want 0", core_hold_o); end
  endtask

  task automatic test_framing();
    clear_mon();
    send_good(0, 3);
    send_byte(8'h00, 1'b0);
    repeat (20) @(negedge clk);
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL frm_err got %b want 1", err_o); end
    n_vec++; if (wr_cnt !== 0) begin n_err++; $display("FAIL frm_wr_cnt got %0d want 0", wr_cnt); end
    n_vec++; if (core_hold_o !== 1'b0) begin n_err++; $display("FAIL frm_hold got %b want 0", core_hold_o); end
    send_good(0, 1);
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL frm_err_clear got %b want 0", err_o); end
    send_good(2, 11);
    repeat (12) @(negedge clk);
    n_vec++; if (wr_cnt !== 2) begin n_err++; $display("FAIL frm_rec_wr_cnt got %0d want 2", wr_cnt); end
    n_vec++; if (wr_data[1] !== 32'h0000_0537) begin n_err++; $display("FAIL frm_rec_data1 got %h want 00000537", wr_data[1]); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL frm_rec_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_len_over();
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (8) @(negedge clk);
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL len_err got %b want 1", err_o); end
    n_vec++; if (core_hold_o !== 1'b0) begin n_err++; $display("FAIL len_hold got %b want 0", core_hold_o); end
    n_vec++; if (wr_cnt !== 0) begin n_err++; $display("FAIL len_wr_cnt got %0d want 0", wr_cnt); end
    n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL len_done got %0d want 0", done_cnt); end
  endtask

  task automatic test_len_zero();
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (8) @(negedge clk);
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL len0_done got %0d want 1", done_cnt); end
    n_vec++; if (wr_cnt !== 0) begin n_err++; $display("FAIL len0_wr_cnt got %0d want 0", wr_cnt); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL len0_err got %b want 0", err_o); end
  endtask

  // 0xA5 inside the payload is data; four of them XOR to 0x00.
  task automatic test_a5_data();
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (8) @(negedge clk);
    n_vec++; if (wr_cnt !== 1) begin n_err++; $display("FAIL a5_wr_cnt got %0d want 1", wr_cnt); end
    n_vec++; if (wr_data[0] !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL a5_data0 got %h want a5a5a5a5", wr_data[0]); end
    n_vec++; if (wr_addr[0] !== 32'h0) begin n_err++; $display("FAIL a5_addr0 got %h want 00000000", wr_addr[0]); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL a5_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_good(0, 4);
    n_vec++; if (core_hold_o !== 1'b1) begin n_err++; $display("FAIL rmid_hold_pre got %b want 1", core_hold_o); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_vec++; if (core_hold_o !== 1'b0) begin n_err++; $display("FAIL rmid_hold got %b want 0", core_hold_o); end
    n_vec++; if (rom_waddr_o !== 32'h0) begin n_err++; $display("FAIL rmid_waddr got %h want 0", rom_waddr_o); end
    n_vec++; if (rom_wdata_o !== 32'h0) begin n_err++; $display("FAIL rmid_wdata got %h want 0", rom_wdata_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL rmid_err got %b want 0", err_o); end
    n_vec++; if (rom_we_o !== 1'b0) begin n_err++; $display("FAIL rmid_we got %b want 0", rom_we_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rmid_done got %b want 0", done_o); end
    repeat (8) @(negedge clk);
    clear_mon();
    send_good(0, 11);
    repeat (12) @(negedge clk);
    n_vec++; if (wr_cnt !== 2) begin n_err++; $display("FAIL rmid_wr_cnt got %0d want 2", wr_cnt); end
    n_vec++; if (wr_addr[0] !== 32'h0) begin n_err++; $display("FAIL rmid_addr0 got %h want 00000000", wr_addr[0]); end
    n_vec++; if (wr_data[0] !== 32'h9300_0013) begin n_err++; $display("FAIL rmid_data0 got %h want 93000013", wr_data[0]); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL rmid_done_cnt got %0d want 1", done_cnt); end
  endtask

  initial begin
    // Payload XOR: 13^00^00^93^37^05^00^00 = B2
    good = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h93,
             8'h37, 8'h05, 8'h00, 8'h00, 8'hB2};
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_noise();
    test_bad_csum();
    test_framing();
    test_len_over();
    test_len_zero();
    test_a5_data();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
